// File: rtl/y_dequantizer.sv
// rtl/y_dequantizer.sv - luminance dequantizer: 64 raster-order coefficients in, saturated 8x8 block out
// Two-stage datapath (capture, multiply/clamp/write) feeding a single block buffer.
module y_dequantizer #(
   parameter logic [511:0] Q_TABLE = {64{8'd1}},
   parameter int           OUT_W   = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [10:0]                    in_coef,
   output logic [7:0][7:0][OUT_W-1:0]     out_block,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_sat
);

   typedef enum logic [1:0] {FILL, DRAIN, FULL} state_t;

   localparam logic signed [19:0] SAT_HI = 20'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [19:0] SAT_LO = ~SAT_HI;

   state_t             state;
   state_t             state_nxt;
   logic               in_ready_nxt;
   logic               out_sat_nxt;
   logic               accept;
   logic [5:0]         k;
   logic               s1_valid;
   logic [5:0]         s1_k;
   logic [10:0]        s1_coef;
   logic               sticky;
   logic [7:0]         q_sel;
   logic signed [19:0] prod;
   logic [OUT_W-1:0]   clamped;
   logic               clamp_hit;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FILL;
         in_ready <= 1'b0;
         out_sat  <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= in_ready_nxt;
         out_sat  <= out_sat_nxt;
      end
   end

   // DRAIN ends once stage 1 holds nothing, i.e. the last coefficient has been written.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && k == 6'd63) state_nxt = DRAIN;
         DRAIN:   if (!s1_valid)            state_nxt = FULL;
         FULL:    if (out_ready)            state_nxt = FILL;
         default:                           state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready_nxt = (state_nxt == FILL);
      out_valid    = (state == FULL);
      out_sat_nxt  = out_sat;
      if (state == DRAIN && state_nxt == FULL)
         out_sat_nxt = sticky;
      else if (state == FULL && state_nxt == FILL)
         out_sat_nxt = 1'b0;
   end

   // Product range is at most 1024*255, so 20 signed bits hold it exactly.
   always_comb begin
      q_sel     = Q_TABLE[{s1_k, 3'b000} +: 8];
      prod      = $signed({{9{s1_coef[10]}}, s1_coef}) * $signed({12'b0, q_sel});
      clamp_hit = 1'b0;
      clamped   = prod[OUT_W-1:0];
      if (prod > SAT_HI) begin
         clamped   = SAT_HI[OUT_W-1:0];
         clamp_hit = 1'b1;
      end else if (prod < SAT_LO) begin
         clamped   = SAT_LO[OUT_W-1:0];
         clamp_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= 6'd0;
         s1_valid  <= 1'b0;
         s1_k      <= 6'd0;
         s1_coef   <= 11'd0;
         sticky    <= 1'b0;
         out_block <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            k       <= k + 6'd1;
            s1_k    <= k;
            s1_coef <= in_coef;
         end
         if (s1_valid)
            out_block[s1_k[5:3]][s1_k[2:0]] <= clamped;
         if (state == FULL && out_ready)
            sticky <= 1'b0;
         else if (s1_valid && clamp_hit)
            sticky <= 1'b1;
      end
   end

endmodule

// File: doc/y_dequantizer.md
Name: y_dequantizer

Overview:
Inverse of the luminance quantizer, used on the decode/verification path. It accepts a stream of 64 quantized 11-bit signed Y coefficients in raster order (row-major; zigzag reorder is done upstream) through a valid/ready handshake. Each coefficient is multiplied by its quantization step and saturated to 12-bit signed. The completed 8x8 block is presented to the IDCT stage with a valid/ready handshake.

Parameters:
- Q_TABLE, default 512'h0101...01 (64 bytes of 8'd1), quantization steps; entry k = bits [8k+7:8k] applies to row k/8, column k%8; unsigned 0..255.
- OUT_W, default 12, output coefficient width (signed).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_coef valid
- in_ready  out  1  block can accept a coefficient
- in_coef  in  11  quantized coefficient, two's complement
- out_block  out  OUT_W x [7:0][7:0]  dequantized block, [row][col], signed
- out_valid  out  1  out_block complete and stable
- out_ready  in  1  consumer takes block
- out_sat  out  1  at least one coefficient of the presented block was clamped

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. On reset, all out_block entries = 0, out_valid = 0, out_sat = 0, in_ready = 0, coefficient index = 0, state = FILL, pipeline valid = 0, sticky saturation = 0.
- States:
  - FILL (in_ready = 1): accepting coefficients.
  - DRAIN (in_ready = 0): waiting for the pipeline to empty.
  - FULL (out_valid = 1): block presented.
- in_ready is registered. It rises on the first clk edge after rst deasserts.
- Accept: a coefficient is accepted when in_valid & in_ready at a clk edge. The index k (6-bit) increments only on accept. When in_valid is low, nothing changes (stalls are allowed anywhere).
- Stage 1, accept edge E: register the coefficient, k, and a stage-valid bit.
- Stage 2, edge E+1: product = coef (sign-extended) x Q_TABLE[k] (zero-extended), computed exactly as a 20-bit signed value with no rounding.
  - Clamp the product to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (default -2048..2047).
  - Write the result to out_block[k/8][k%8].
  - If clamping occurred, set the sticky saturation bit.
  - A Q entry of 0 yields 0, with no saturation.
- On accepting k = 63: in_ready clears at that same edge, k wraps to 0, and state goes FILL -> DRAIN.
- DRAIN -> FULL: at edge E+2 after the k = 63 accept, out_valid = 1 and out_sat = sticky bit. Latency from the last accept to out_valid high is exactly 2 clocks.
- FULL:
  - out_block and out_sat are held constant, and in_ready = 0. in_valid is ignored.
  - At an edge with out_ready = 1: out_valid -> 0, out_sat -> 0, sticky bit -> 0, in_ready -> 1, state -> FILL.
  - out_ready while not FULL is ignored.
- Throughput: at most one block per 67 clocks (64 accepts + 2 drain + 1 handoff). The block buffer is single; there is no overlap of fill and presentation.
- During FILL/DRAIN, out_block entries of the new block overwrite in index order. Unwritten entries retain their previous values. Contents are guaranteed only while out_valid = 1.
- Reset mid-block: the partial block is discarded, all state returns to reset values, and the next accepted coefficient is k = 0.
- in_coef value -1024 is legal and must saturate correctly for any Q greater than 2.

Test Plan:
- Default Q_TABLE, in_coef = k for k = 0..63, continuous in_valid, out_ready = 1 -> out_block[i][j] = 8i+j, out_sat = 0, out_valid high exactly 2 clocks after the 64th accept, in_ready low 3 cycles total.
- Q_TABLE all 16, all in_coef = -5 except k = 0 = 200 and k = 1 = -1024 -> out_block[0][0] = 2047, [0][1] = -2048, others -80, out_sat = 1.
- Backpressure: out_ready low 10 cycles after out_valid, in_valid held high -> block and out_sat stable, no accepts. Then out_ready = 1 -> in_ready = 1 next cycle; next block of all 1 (Q = 16) gives all 16 with out_sat = 0.
- Random in_valid gaps (about 50% duty) with the same data as test 1 -> identical out_block; accept count exactly 64 before in_ready drops.
- Assert rst after 30 accepts -> all outputs 0 immediately. After release, 64 fresh coefficients give a correct block with no leftover data or sticky saturation.
- Q_TABLE entry 9 = 0, entry 10 = 255, in_coef = 8 everywhere -> out_block[1][1] = 0, [1][2] = 2040, out_sat = 0.
